// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants, FSM state type and channel extraction for the TDM frame sender.
package tdm_pkg;
  localparam int NUM_CH = 8;
  localparam int SEL_W = 3;
  localparam int MAX_W = 32;
  typedef enum logic {IDLE, SEND} state_t;
  // Frame is zero-extended to the widest supported byte width so one function serves any DATA_W <= MAX_W.
  function automatic logic [MAX_W-1:0] ch_word(input logic [NUM_CH*MAX_W-1:0] f, input int unsigned w, input logic [SEL_W-1:0] k);
    return MAX_W'(f >> (32'(k) * w));
  endfunction
endpackage

// File: rtl/tdm_hold_timer.sv
// tdm_hold_timer: counts HOLD enabled cycles per channel and pulses tc_o on the last one.
module tdm_hold_timer #(
  parameter int HOLD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD - 1);
  logic [CW-1:0] cnt_q;
  assign tc_o = enable_i && cnt_q == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (clear_i || tc_o) cnt_q <= '0;
    else if (enable_i) cnt_q <= cnt_q + 1'b1;
endmodule

// File: rtl/tdm_frame_sender.sv
// tdm_frame_sender: accepts an 8-channel frame and presents each channel byte with its select for HOLD cycles.
module tdm_frame_sender
  import tdm_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int HOLD = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     iValid,
  input  logic [NUM_CH*DATA_W-1:0] iFrame,
  output logic                     oReady,
  output logic [DATA_W-1:0]        oData,
  output logic                     A,
  output logic                     B,
  output logic                     C,
  output logic                     oBusy,
  output logic                     oFrameDone
);
  localparam int FW = NUM_CH * DATA_W;
  localparam int PW = NUM_CH * MAX_W;
  state_t state_q;
  logic [FW-1:0] frame_q;
  logic [DATA_W-1:0] data_q;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic done_q, tc, last, accept;
  logic [DATA_W-1:0] next_byte;
  tdm_hold_timer #(.HOLD(HOLD)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clear_i(accept),
    .enable_i(state_q == SEND),
    .tc_o(tc)
  );
  assign last = tc && ch_q == SEL_W'(NUM_CH - 1);
  assign oReady = state_q == IDLE || last;
  assign accept = iValid && oReady;
  assign ch_d = ch_q + 1'b1;
  assign next_byte = DATA_W'(ch_word(PW'(frame_q), DATA_W, ch_d));
  assign oData = data_q;
  assign {A, B, C} = ch_q;
  assign oBusy = state_q == SEND;
  assign oFrameDone = done_q;
  // A same-cycle accept at end of frame takes priority so the next frame starts without a gap.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      frame_q <= '0;
      data_q <= '0;
      ch_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        state_q <= SEND;
        frame_q <= iFrame;
        data_q <= iFrame[DATA_W-1:0];
        ch_q <= '0;
      end else if (last) begin
        state_q <= IDLE;
        data_q <= '0;
        ch_q <= '0;
      end else if (tc) begin
        data_q <= next_byte;
        ch_q <= ch_d;
      end
    end
endmodule
